// File: rtl/vp_ps2_pkg.sv
// Shared types and timing helpers for the PS/2 host-to-device transmit path.
package vp_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  // Cycles for freq_khz * amount / div (div=1000 for microseconds, div=1 for milliseconds).
  function automatic int unsigned ps2_cycles(input int unsigned freq_khz,
                                             input int unsigned amount,
                                             input int unsigned div);
    longint unsigned prod;
    prod = 64'(freq_khz) * 64'(amount);
    return 32'(prod / 64'(div));
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a run-length filter for one open-drain PS/2 pin.
// The filtered level only moves after FILT_LEN consecutive samples disagree with it.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic res_n_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Idle bus is high, so the filter wakes up believing the line is released.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_o <= 1'b1;
      fall_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      fall_o <= 1'b0;
      if (sync_q[1] == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        level_o <= sync_q[1];
        cnt_q   <= '0;
        fall_o  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, then
// shifts data/parity/stop on device clock falls and checks the device acknowledge.
module ps2_host_tx
  import vp_ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ = 70938,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned TIMEOUT_MS   = 20,
  parameter int unsigned FILT_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic       busy_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int unsigned INHIBIT_CYC = ps2_cycles(CLK_FREQ_KHZ, INHIBIT_US, 1000);
  localparam int unsigned TO_CYC      = ps2_cycles(CLK_FREQ_KHZ, TIMEOUT_MS, 1);
  localparam int          WD_W        = $clog2(TO_CYC + 1);
  localparam int          INH_W       = $clog2(INHIBIT_CYC + 1);

  ps2_tx_state_t state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done, err;
  logic             clk_level, clk_fall;
  logic             dat_level, unused_dat_fall;

  ps2_line_filter #(.FILT_LEN(int'(FILT_LEN))) u_clk_filt (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .pin_i   (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(.FILT_LEN(int'(FILT_LEN))) u_dat_filt (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .pin_i   (ps2_dat_i),
    .level_o (dat_level),
    .fall_o  (unused_dat_fall)
  );

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wd_cnt_q  <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  // Watchdog expiry overrides everything, including a clock fall in the same cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done      = 1'b0;
    err       = 1'b0;

    if (state_q != ST_IDLE) wd_cnt_d = wd_cnt_q - WD_W'(1);

    if (state_q != ST_IDLE && wd_cnt_q == '0) begin
      state_d  = ST_IDLE;
      wd_cnt_d = '0;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done     = 1'b1;
      err      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid_i) begin
            data_d    = tx_data_i;
            par_d     = ~^tx_data_i;
            wd_cnt_d  = WD_W'(TO_CYC - 1);
            inh_cnt_d = INH_W'(INHIBIT_CYC - 1);
            clk_oe_d  = 1'b1;
            dat_oe_d  = 1'b0;
            state_d   = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt_q == '0) begin
            dat_oe_d = 1'b1;
            state_d  = ST_RTS;
          end else begin
            inh_cnt_d = inh_cnt_q - INH_W'(1);
          end
        end
        ST_RTS: begin
          clk_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (clk_fall) begin
            dat_oe_d = ~data_q[bit_cnt_q];
            if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          if (clk_fall) begin
            dat_oe_d = ~par_q;
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          if (clk_fall) begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            nack_d  = dat_level;
            state_d = ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_level && dat_level) begin
            done    = 1'b1;
            err     = nack_q;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Let go of the pins one cycle early so they are already free when the timeout is reported.
      if (state_d != ST_IDLE && wd_cnt_d == '0) begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    end
  end

  assign tx_ready_o   = (state_q == ST_IDLE);
  assign busy_o       = ~tx_ready_o;
  assign tx_done_o    = done;
  assign tx_err_o     = err;
  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames out of the host while a
// scoreboard of expected bytes/parity/ack results is checked against frames and done pulses.
module tb_ps2_host_tx;

  // Scaled-down timing: 1 MHz system clock gives 100 inhibit cycles and a 5000-cycle watchdog.
  localparam int unsigned CLK_FREQ_KHZ = 1000;
  localparam int unsigned INHIBIT_US   = 100;
  localparam int unsigned TIMEOUT_MS   = 5;
  localparam int unsigned FILT_LEN     = 8;
  localparam int INHIBIT_CYC = 100;
  localparam int TO_CYC      = 5000;
  localparam int HALF        = 40;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;

  typedef struct {
    int   cyc;
    logic err;
    logic clk_oe;
    logic dat_oe;
    logic ready_next;
  } done_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_o, tx_done_o, tx_err_o, busy_o;
  logic       ps2_clk_oe_o, ps2_dat_oe_o;
  logic       dev_clk, dev_dat, glitch;
  logic       ps2_clk, ps2_dat;

  exp_t  exp_q[$];
  done_t done_q[$];
  acc_t  acc_q[$];
  int    cyc;
  int    total;
  int    bad;

  assign ps2_clk = dev_clk & ~ps2_clk_oe_o & ~glitch;
  assign ps2_dat = dev_dat & ~ps2_dat_oe_o;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_KHZ (CLK_FREQ_KHZ),
    .INHIBIT_US   (INHIBIT_US),
    .TIMEOUT_MS   (TIMEOUT_MS),
    .FILT_LEN     (FILT_LEN)
  ) dut (
    .clk_i        (clk),
    .res_n_i      (res_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready_o),
    .tx_done_o    (tx_done_o),
    .tx_err_o     (tx_err_o),
    .busy_o       (busy_o),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .ps2_clk_oe_o (ps2_clk_oe_o),
    .ps2_dat_oe_o (ps2_dat_oe_o)
  );

  // Output monitor, sampling mid low-phase: records accepts and done pulses with cycle stamps.
  initial begin
    done_t pend_rec;
    bit    pend;
    pend = 0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        pend_rec.ready_next = tx_ready_o;
        done_q.push_back(pend_rec);
        pend = 0;
      end
      if (tx_done_o) begin
        pend_rec = '{cyc: cyc, err: tx_err_o, clk_oe: ps2_clk_oe_o,
                     dat_oe: ps2_dat_oe_o, ready_next: 1'b0};
        pend = 1;
      end
      if (tx_valid && tx_ready_o) acc_q.push_back('{cyc: cyc, data: tx_data});
      cyc++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic exp_err);
    int n0;
    int n;
    n0 = acc_q.size();
    n  = 0;
    exp_q.push_back('{data: d, par: ~^d, err: exp_err});
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (acc_q.size() == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    checkOutput("accept_count", acc_q.size() - n0, 1);
    checkOutput("ready_after_accept", tx_ready_o, 1'b0);
    checkOutput("clk_oe_after_accept", ps2_clk_oe_o, 1'b1);
  endtask

  // Device side: wait for request-to-send, then generate nclk clock pulses, reading on the high phase.
  task automatic device_frame(input int nclk, input logic ack_bit, input int glitch_clk,
                              output logic [10:0] bits, output int inh_cycles);
    int n;
    n          = 0;
    bits       = '0;
    inh_cycles = ps2_clk_oe_o ? 1 : 0;
    while (!(ps2_clk_oe_o == 1'b0 && ps2_dat_oe_o == 1'b1) && n < 2 * INHIBIT_CYC + 50) begin
      @(negedge clk);
      n++;
      if (ps2_clk_oe_o) inh_cycles++;
    end
    checkOutput("rts_seen", (ps2_clk_oe_o == 1'b0 && ps2_dat_oe_o == 1'b1), 1);
    bits[0] = ps2_dat;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        if (k == glitch_clk && c == 5) glitch = 1'b1;
        if (k == glitch_clk && c == 8) glitch = 1'b0;
        if (c == HALF / 2 && k <= 10) bits[k] = ps2_dat;
        if (c == HALF / 2 + 2 && k == 10) dev_dat = ack_bit;
        @(negedge clk);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic check_frame(input logic [10:0] bits);
    exp_t e;
    checkOutput("frame_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      checkOutput("start_bit", bits[0], 1'b0);
      checkOutput("data_bits", bits[8:1], e.data);
      checkOutput("parity_bit", bits[9], e.par);
      checkOutput("stop_bit", bits[10], 1'b1);
    end
  endtask

  task automatic wait_done(input int budget, output done_t rec);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done_q.size() != 0, 1);
    if (done_q.size() != 0) rec = done_q.pop_front();
    else rec = '{cyc: -1, err: 1'bx, clk_oe: 1'bx, dat_oe: 1'bx, ready_next: 1'bx};
  endtask

  task automatic finish_txn(input done_t rec);
    exp_t e;
    checkOutput("scoreboard_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("done_err", rec.err, e.err);
    end
    checkOutput("done_clk_oe", rec.clk_oe, 1'b0);
    checkOutput("done_dat_oe", rec.dat_oe, 1'b0);
    checkOutput("ready_after_done", rec.ready_next, 1'b1);
  endtask

  initial begin
    logic [10:0] bits;
    int          inh;
    done_t       rec;
    acc_t        a;
    int          n;
    int          n0;

    total    = 0;
    bad      = 0;
    res_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    glitch   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", tx_ready_o, 1'b1);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", tx_done_o, 1'b0);
    checkOutput("rst_err", tx_err_o, 1'b0);
    checkOutput("rst_clk_oe", ps2_clk_oe_o, 1'b0);
    checkOutput("rst_dat_oe", ps2_dat_oe_o, 1'b0);
    res_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] set-LEDs command 0xED with ack");
    applyStimulus(8'hED, 1'b0);
    device_frame(11, 1'b0, 0, bits, inh);
    checkOutput("inhibit_len", inh, INHIBIT_CYC + 1);
    check_frame(bits);
    wait_done(300, rec);
    finish_txn(rec);
    repeat (30) @(negedge clk);

    $display("[TB] silent device, watchdog expiry");
    applyStimulus(8'h3C, 1'b1);
    a = acc_q[acc_q.size() - 1];
    wait_done(TO_CYC + 200, rec);
    checkOutput("timeout_cycles", rec.cyc - a.cyc, TO_CYC);
    finish_txn(rec);
    repeat (30) @(negedge clk);

    $display("[TB] reset command 0xFF with nack");
    applyStimulus(8'hFF, 1'b1);
    device_frame(11, 1'b1, 0, bits, inh);
    check_frame(bits);
    wait_done(300, rec);
    finish_txn(rec);
    repeat (30) @(negedge clk);

    $display("[TB] clock glitch during data bits");
    applyStimulus(8'h96, 1'b0);
    device_frame(11, 1'b0, 3, bits, inh);
    check_frame(bits);
    wait_done(300, rec);
    finish_txn(rec);
    repeat (30) @(negedge clk);

    $display("[TB] async reset in the middle of the data bits");
    applyStimulus(8'hA5, 1'b0);
    device_frame(4, 1'b0, 0, bits, inh);
    checkOutput("pre_reset_dat_oe", ps2_dat_oe_o, 1'b1);
    #2;
    res_n = 1'b0;
    #1;
    checkOutput("async_rst_clk_oe", ps2_clk_oe_o, 1'b0);
    checkOutput("async_rst_dat_oe", ps2_dat_oe_o, 1'b0);
    checkOutput("async_rst_ready", tx_ready_o, 1'b1);
    void'(exp_q.pop_back());
    @(negedge clk);
    res_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("post_reset_ready", tx_ready_o, 1'b1);
    checkOutput("post_reset_no_done", done_q.size(), 0);

    $display("[TB] back-to-back 0x55 then 0xAA with valid held");
    n0 = acc_q.size();
    exp_q.push_back('{data: 8'h55, par: ~^8'h55, err: 1'b0});
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    n = 0;
    while (acc_q.size() == n0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx_data = 8'hAA;
    exp_q.push_back('{data: 8'hAA, par: ~^8'hAA, err: 1'b0});
    device_frame(11, 1'b0, 0, bits, inh);
    check_frame(bits);
    n = 0;
    while (acc_q.size() < n0 + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    checkOutput("b2b_accept_count", acc_q.size() - n0, 2);
    wait_done(300, rec);
    if (acc_q.size() >= n0 + 2) begin
      checkOutput("b2b_second_data", acc_q[n0 + 1].data, 8'hAA);
      checkOutput("b2b_accept_after_done", acc_q[n0 + 1].cyc - rec.cyc, 1);
    end
    finish_txn(rec);
    device_frame(11, 1'b0, 0, bits, inh);
    check_frame(bits);
    wait_done(300, rec);
    finish_txn(rec);
    repeat (30) @(negedge clk);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("no_stray_done", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
